// File: rtl/mem_access_ctrl_if.sv
//==============================================================================
// Module      : mem_access_ctrl_if
// Description : Request/response and RAM handshake bundle for mem_access_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mem_access_ctrl_if;
    // Datapath request side
    logic        req;
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    // RAM handshake side
    logic        mem_mov;
    logic        mem_rw;
    logic [2:0]  mem_ms;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_mocoff;
    logic        mem_moc;
    logic [31:0] mem_dataout;

    // master: the datapath plus the RAM that surround the sequencer
    modport master (
        output req, rw, size, sgn, addr, wdata, mem_moc, mem_dataout,
        input  busy, done, err, rdata,
        input  mem_mov, mem_rw, mem_ms, mem_addr, mem_datain, mem_mocoff
    );

    modport slave (
        input  req, rw, size, sgn, addr, wdata, mem_moc, mem_dataout,
        output busy, done, err, rdata,
        output mem_mov, mem_rw, mem_ms, mem_addr, mem_datain, mem_mocoff
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
//==============================================================================
// Module      : mem_access_ctrl
// Description : Load/store sequencer for the async byte RAM (MOV/MOC/MOCoff).
//               Optional MOC timeout enabled by defining MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire               clk,
    input  wire               rst_n,
    mem_access_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_ACCESS  = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      r_state;
    state_t      w_state_nx;
    logic        w_valid;
    logic        w_accept;
    logic        w_capture;
    logic        w_err_nx;

    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_mov;
    logic        r_rw;
    logic [2:0]  r_ms;
    logic [31:0] r_addr;
    logic [31:0] r_datain;
    logic        r_mocoff;

`ifdef MEM_TIMEOUT_EN
    logic [7:0]  r_cnt;
    logic        r_to;
    logic        w_to_hit;

    assign w_to_hit = (r_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        unique case (bus.size)
            2'b00:   w_valid = 1'b1;
            2'b01:   w_valid = ~bus.addr[0];
            2'b10:   w_valid = (bus.addr[1:0] == 2'b00);
            default: w_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        w_err_nx   = 1'b0;
        unique case (r_state)
            S_INIT: w_state_nx = S_IDLE;
            S_IDLE: begin
                if (bus.req) begin
                    if (w_valid) begin
                        w_state_nx = S_ACCESS;
                        w_accept   = 1'b1;
                    end else begin
                        w_state_nx = S_DONE;
                        w_err_nx   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                // A MOC arriving on the timeout cycle still counts as success
                if (bus.mem_moc) begin
                    w_state_nx = S_RELEASE;
                    w_capture  = r_rw;
`ifdef MEM_TIMEOUT_EN
                end else if (w_to_hit) begin
                    w_state_nx = S_RELEASE;
`endif
                end
            end
            S_RELEASE: begin
                if (!bus.mem_moc) begin
                    w_state_nx = S_DONE;
`ifdef MEM_TIMEOUT_EN
                    w_err_nx   = r_to;
`endif
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_INIT;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_INIT;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_mov    <= 1'b0;
            r_rw     <= 1'b0;
            r_ms     <= 3'd0;
            r_addr   <= 32'd0;
            r_datain <= 32'd0;
            r_mocoff <= 1'b1;
        end else begin
            r_state  <= w_state_nx;
            r_busy   <= (w_state_nx != S_IDLE);
            r_done   <= (w_state_nx == S_DONE);
            r_err    <= (w_state_nx == S_DONE) && w_err_nx;
            r_mov    <= (w_state_nx == S_ACCESS);
            r_mocoff <= (w_state_nx == S_INIT) || (w_state_nx == S_RELEASE);
            if (w_accept) begin
                r_rw     <= bus.rw;
                r_ms     <= {bus.sgn, bus.size};
                r_addr   <= bus.addr;
                r_datain <= bus.wdata;
            end
            if (w_capture) begin
                r_rdata <= bus.mem_dataout;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
            r_to  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= 8'd0;
            r_to  <= 1'b0;
        end else if (r_state == S_ACCESS && !bus.mem_moc) begin
            r_cnt <= r_cnt + 8'd1;
            if (w_to_hit) begin
                r_to <= 1'b1;
            end
        end
    end
`endif

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.rdata      = r_rdata;
    assign bus.mem_mov    = r_mov;
    assign bus.mem_rw     = r_rw;
    assign bus.mem_ms     = r_ms;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_datain = r_datain;
    assign bus.mem_mocoff = r_mocoff;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
//==============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl with a behavioural RAM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i << 3) ^ 8'(i >> 5);
    endfunction

    // Behavioural asynchronous RAM: MOC after a programmable delay, held
    // for a programmable number of cycles after MOCoff appears.
    logic [7:0] ram [256];
    int  ram_delay = 0;
    int  ram_hold  = 0;
    bit  ram_dead  = 1'b0;
    int  dly_cnt   = 0;
    int  hold_cnt  = 0;
    bit  ram_inited = 1'b0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_moc     = 1'b0;
            bus.mem_dataout = 32'd0;
            dly_cnt  = 0;
            hold_cnt = 0;
            if (!ram_inited) begin
                for (int i = 0; i < 256; i++) ram[i] = pat(i);
                ram_inited = 1'b1;
            end
        end else if (bus.mem_mocoff) begin
            if (hold_cnt > 0) hold_cnt--;
            else bus.mem_moc = 1'b0;
        end else if (bus.mem_mov && !bus.mem_moc && !ram_dead) begin
            if (dly_cnt >= ram_delay) begin
                int n;
                logic [31:0] v;
                n = (bus.mem_ms[1:0] == 2'b00) ? 1 : (bus.mem_ms[1:0] == 2'b01) ? 2 : 4;
                v = 32'd0;
                for (int i = 0; i < n; i++) begin
                    if (bus.mem_rw) v[8*i +: 8] = ram[8'(bus.mem_addr[7:0] + 8'(i))];
                    else ram[8'(bus.mem_addr[7:0] + 8'(i))] = bus.mem_datain[8*i +: 8];
                end
                if (bus.mem_ms[2] && n < 4 && v[8*n-1]) begin
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                bus.mem_dataout = v;
                bus.mem_moc  = 1'b1;
                dly_cnt  = 0;
                hold_cnt = ram_hold;
            end else begin
                dly_cnt++;
            end
        end
    end

    // Reference model: byte array plus last-good-read register
    logic [7:0]  ref_mem [256];
    logic [31:0] ref_rdata = 32'd0;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic s);
        int n = nbytes(sz);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[8'(a[7:0] + 8'(i))]) << (8 * i);
        if (s && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[8'(a[7:0] + 8'(i))] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    task automatic txn(input logic r, input logic [1:0] sz, input logic s,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int dly, input int hld, input bit dead, input string tag);
        int   lat, exp_lat;
        bit   bad_bus, mov_seen, mocoff_seen;
        logic exp_bad, exp_err;
        exp_bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        exp_err = exp_bad || dead;
        exp_lat = exp_bad ? 1 : dead ? TO + 2 : 3 + dly + hld;
        if (!exp_err) begin
            if (r) ref_rdata = ref_load(a, sz, s);
            else   ref_store(a, sz, wd);
        end
        ram_delay = dly; ram_hold = hld; ram_dead = dead;
        bus.req = 1'b1; bus.rw = r; bus.size = sz; bus.sgn = s; bus.addr = a; bus.wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        lat = 1; bad_bus = 1'b0; mov_seen = 1'b0; mocoff_seen = 1'b0;
        while (!bus.done && lat < 400) begin
            if (bus.mem_mov) begin
                mov_seen = 1'b1;
                if (bus.mem_addr !== a || bus.mem_rw !== r || bus.mem_ms !== {s, sz} ||
                    (!r && bus.mem_datain !== wd)) bad_bus = 1'b1;
            end
            if (bus.mem_mocoff) mocoff_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, {31'd0, bus.err}, {31'd0, exp_err});
        check({tag, " rdata"}, bus.rdata, ref_rdata);
        check({tag, " mov_seen"}, {31'd0, mov_seen}, {31'd0, !exp_bad});
        check({tag, " bus_stable"}, {31'd0, bad_bus}, 32'd0);
        check({tag, " mov_at_done"}, {31'd0, bus.mem_mov}, 32'd0);
        if (!exp_bad) check({tag, " mocoff_pulse"}, {31'd0, mocoff_seen}, 32'd1);
        @(negedge clk);
        check({tag, " done_one_cycle"}, {30'd0, bus.done, bus.busy}, 32'd0);
        ram_dead = 1'b0;
    endtask

    initial begin
        int dones, rises;
        bit prev, bad;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        bus.req = 1'b0; bus.rw = 1'b0; bus.size = 2'b00; bus.sgn = 1'b0;
        bus.addr = 32'd0; bus.wdata = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst mocoff", {31'd0, bus.mem_mocoff}, 32'd1);
        check("rst busy", {31'd0, bus.busy}, 32'd1);
        check("rst flags", {28'd0, bus.done, bus.err, bus.mem_mov, bus.mem_rw}, 32'd0);
        check("rst ms", {29'd0, bus.mem_ms}, 32'd0);
        check("rst rdata", bus.rdata, 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'd0);
        check("rst datain", bus.mem_datain, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-init idle", {30'd0, bus.busy, bus.mem_mocoff}, 32'd0);

        // Directed cases
        txn(1'b1, 2'b00, 1'b1, 32'h10, 32'd0, 0, 0, 1'b0, "sbyte_rd");
        check("sbyte value", bus.rdata, 32'hFFFFFF80);
        check("sbyte ms", {29'd0, bus.mem_ms}, 32'b100);
        txn(1'b0, 2'b00, 1'b0, 32'h21, 32'h5A, 1, 1, 1'b0, "byte_wr");
        check("byte_wr keeps rdata", bus.rdata, 32'hFFFFFF80);
        txn(1'b1, 2'b00, 1'b0, 32'h21, 32'd0, 2, 0, 1'b0, "ubyte_rd");
        check("ubyte value", bus.rdata, 32'h0000005A);
        txn(1'b1, 2'b01, 1'b0, 32'h11, 32'd0, 0, 0, 1'b0, "mis_half");
        txn(1'b1, 2'b10, 1'b0, 32'h22, 32'd0, 0, 0, 1'b0, "mis_word");
        txn(1'b0, 2'b11, 1'b0, 32'h20, 32'h1234, 0, 0, 1'b0, "rsv_size");
        check("errors keep rdata", bus.rdata, 32'h0000005A);
`ifdef MEM_TIMEOUT_EN
        txn(1'b1, 2'b10, 1'b0, 32'h40, 32'd0, 0, 0, 1'b1, "timeout");
        check("timeout keeps rdata", bus.rdata, 32'h0000005A);
`endif

        // Randomized transactions
        for (int k = 0; k < 30; k++) begin
            txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, "rand");
        end

        // req held high across transactions: one done per accepted request
        ram_delay = 1; ram_hold = 0;
        bus.req = 1'b1; bus.rw = 1'b1; bus.size = 2'b10; bus.sgn = 1'b0; bus.addr = 32'h0000_0040;
        ref_rdata = ref_load(32'h40, 2'b10, 1'b0);
        dones = 0; rises = 0; prev = 1'b0; bad = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.mem_mov && !prev) rises++;
            if (bus.mem_mov && bus.mem_addr !== 32'h40) bad = 1'b1;
            prev = bus.mem_mov;
        end
        bus.req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("flood dones", 32'(dones), 32'd5);
        check("flood accepts", 32'(rises), 32'd5);
        check("flood addr stable", {31'd0, bad}, 32'd0);
        check("flood rdata", bus.rdata, ref_rdata);

        // Asynchronous reset in the middle of ACCESS
        ram_delay = 5;
        bus.req = 1'b1; bus.rw = 1'b1; bus.size = 2'b00; bus.addr = 32'h33;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("pre-reset mov", {31'd0, bus.mem_mov}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst mov", {31'd0, bus.mem_mov}, 32'd0);
        check("async rst mocoff/busy", {30'd0, bus.mem_mocoff, bus.busy}, 32'd3);
        check("async rst rdata", bus.rdata, 32'd0);
        ref_rdata = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init after rst", {30'd0, bus.mem_mocoff, bus.busy}, 32'd3);
        @(negedge clk);
        check("idle after init", {30'd0, bus.mem_mocoff, bus.busy}, 32'd0);
        txn(1'b1, 2'b01, 1'b1, 32'h80, 32'd0, 0, 0, 1'b0, "post_rst_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
